// File: rtl/cache_refill_ctrl.sv
// Miss sequencer between the direct-mapped cache array and the SDRAM controller FIFOs.
// Define DIRTY_TRACK_EN to evict only dirty valid victims; otherwise every valid victim is written back.
module cache_refill_ctrl #(
  parameter int OFFSETWIDTH = 5,
  parameter int INDEXWIDTH  = 11
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              miss,
  input  logic [23:0]                       miss_addr,
  input  logic                              victim_valid,
  input  logic                              victim_dirty,
  input  logic [24-INDEXWIDTH-OFFSETWIDTH-1:0] victim_tag,
  output logic                              busy,
  output logic                              done,
  output logic [INDEXWIDTH-1:0]             line_index,
  output logic [OFFSETWIDTH-2:0]            word_sel,
  input  logic [15:0]                       line_rd_data,
  output logic                              line_wr_en,
  output logic [15:0]                       line_wr_data,
  output logic                              tag_wr,
  output logic [24-INDEXWIDTH-OFFSETWIDTH-1:0] tag_out,
  output logic                              valid_out,
  output logic [23:0]                       ram_addr,
  output logic                              readreq,
  output logic                              writereq,
  output logic                              read,
  output logic                              write,
  input  logic                              readready,
  input  logic                              writeready,
  input  logic [15:0]                       data_from_ram,
  output logic [15:0]                       data_to_ram
);

  localparam int TAGWIDTH = 24 - INDEXWIDTH - OFFSETWIDTH;
  localparam int WSELW    = OFFSETWIDTH - 1;
  localparam logic [WSELW-1:0] LAST_WORD = '1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RDREQ = 3'd1;
  localparam logic [2:0] S_WRREQ = 3'd2;
  localparam logic [2:0] S_EVICT = 3'd3;
  localparam logic [2:0] S_INVAL = 3'd4;
  localparam logic [2:0] S_FILL  = 3'd5;
  localparam logic [2:0] S_TAG   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [WSELW-1:0]      word_cnt;
  logic [INDEXWIDTH-1:0] cap_index;
  logic [TAGWIDTH-1:0]   cap_tag;
  logic [TAGWIDTH-1:0]   cap_vtag;
  logic                  cap_evict;
  logic                  evict_req;
  logic                  unused_bits;
  logic                  word_step;

`ifdef DIRTY_TRACK_EN
  assign evict_req   = victim_valid & victim_dirty;
  assign unused_bits = ^miss_addr[OFFSETWIDTH-1:0];
`else
  // Without dirty tracking any valid victim may differ from memory, so it is always written back.
  assign evict_req   = victim_valid;
  assign unused_bits = ^{victim_dirty, miss_addr[OFFSETWIDTH-1:0]};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (miss) state_nxt = S_RDREQ;
      S_RDREQ: state_nxt = cap_evict ? S_WRREQ : S_INVAL;
      S_WRREQ: state_nxt = S_EVICT;
      S_EVICT: if (writeready && (word_cnt == LAST_WORD)) state_nxt = S_INVAL;
      S_INVAL: state_nxt = S_FILL;
      S_FILL:  if (readready && (word_cnt == LAST_WORD)) state_nxt = S_TAG;
      S_TAG:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The word counter wraps to 0 after the last word, so it is already 0 when FILL starts.
  assign word_step = ((state == S_EVICT) && writeready) || ((state == S_FILL) && readready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      cap_index <= '0;
      cap_tag   <= '0;
      cap_vtag  <= '0;
      cap_evict <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && miss) begin
        cap_index <= miss_addr[23 -: INDEXWIDTH];
        cap_tag   <= miss_addr[OFFSETWIDTH +: TAGWIDTH];
        cap_vtag  <= victim_tag;
        cap_evict <= evict_req;
      end
      if (word_step) word_cnt <= word_cnt + 1'b1;
    end
  end

  always_comb begin
    ram_addr = '0;
    if (state == S_RDREQ) ram_addr = {cap_index, cap_tag, {OFFSETWIDTH{1'b0}}};
    else if (state == S_WRREQ) ram_addr = {cap_index, cap_vtag, {OFFSETWIDTH{1'b0}}};
  end

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign readreq      = (state == S_RDREQ);
  assign writereq     = (state == S_WRREQ);
  assign write        = (state == S_EVICT) && writeready;
  assign read         = (state == S_FILL) && readready;
  assign line_wr_en   = read;
  assign line_wr_data = data_from_ram;
  assign data_to_ram  = line_rd_data;
  // Invalidate before the fill so a partially refilled line is never seen valid.
  assign tag_wr       = (state == S_INVAL) || (state == S_TAG);
  assign valid_out    = (state == S_TAG);
  assign tag_out      = cap_tag;
  assign line_index   = cap_index;
  assign word_sel     = word_cnt;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: a step-script model predicts every output each cycle.
module tb_cache_refill_ctrl;
  localparam int OW = 5;
  localparam int IW = 11;
  localparam int TW = 8;

  localparam int K_IDLE  = 0;
  localparam int K_RDREQ = 1;
  localparam int K_WRREQ = 2;
  localparam int K_EVICT = 3;
  localparam int K_INVAL = 4;
  localparam int K_FILL  = 5;
  localparam int K_TAG   = 6;
  localparam int K_DONE  = 7;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          miss;
  logic [23:0]   miss_addr;
  logic          victim_valid;
  logic          victim_dirty;
  logic [TW-1:0] victim_tag;
  logic          busy;
  logic          done;
  logic [IW-1:0] line_index;
  logic [OW-2:0] word_sel;
  logic [15:0]   line_rd_data;
  logic          line_wr_en;
  logic [15:0]   line_wr_data;
  logic          tag_wr;
  logic [TW-1:0] tag_out;
  logic          valid_out;
  logic [23:0]   ram_addr;
  logic          readreq;
  logic          writereq;
  logic          read;
  logic          write;
  logic          readready;
  logic          writeready;
  logic [15:0]   data_from_ram;
  logic [15:0]   data_to_ram;

  // Cache array contents: word i of the victim line holds 16'hA00i.
  assign line_rd_data = {12'hA00, word_sel};

  cache_refill_ctrl #(.OFFSETWIDTH(OW), .INDEXWIDTH(IW)) dut (
    .clock(clock), .reset_n(reset_n), .miss(miss), .miss_addr(miss_addr),
    .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .busy(busy), .done(done), .line_index(line_index), .word_sel(word_sel),
    .line_rd_data(line_rd_data), .line_wr_en(line_wr_en), .line_wr_data(line_wr_data),
    .tag_wr(tag_wr), .tag_out(tag_out), .valid_out(valid_out), .ram_addr(ram_addr),
    .readreq(readreq), .writereq(writereq), .read(read), .write(write),
    .readready(readready), .writeready(writeready), .data_from_ram(data_from_ram),
    .data_to_ram(data_to_ram)
  );

  always #5 clock = ~clock;

  typedef struct {
    int kind;
    int word;
  } step_t;

  step_t         q[$];
  logic [IW-1:0] m_idx;
  logic [TW-1:0] m_tag;
  logic [TW-1:0] m_vtag;
  int            total = 0;
  int            bad = 0;
  int            edge_cnt = 0;
  int            acc_edge = 0;
  int            done_edge = 0;
  int            readreq_cnt, writereq_cnt, read_cnt, write_cnt, tag0_cnt, tag1_cnt;
  logic [23:0]   rd_addr_seen, wr_addr_seen;
  logic          done_seen;
  logic [15:0]   filled[16];
  logic [15:0]   evicted[16];
  bit            pop_pending;
  int            pop_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic void push(input int kd, input int wd);
    step_t s;
    s.kind = kd;
    s.word = wd;
    q.push_back(s);
  endfunction

  task automatic accept_miss();
    bit ev;
    m_idx  = miss_addr[23:13];
    m_tag  = miss_addr[12:5];
    m_vtag = victim_tag;
`ifdef DIRTY_TRACK_EN
    ev = victim_valid && victim_dirty;
`else
    ev = victim_valid;
`endif
    push(K_RDREQ, 0);
    if (ev) begin
      push(K_WRREQ, 0);
      for (int i = 0; i < 16; i++) push(K_EVICT, i);
    end
    push(K_INVAL, 0);
    for (int i = 0; i < 16; i++) push(K_FILL, i);
    push(K_TAG, 0);
    push(K_DONE, 0);
    readreq_cnt = 0; writereq_cnt = 0; read_cnt = 0; write_cnt = 0;
    tag0_cnt = 0; tag1_cnt = 0; done_seen = 1'b0;
    rd_addr_seen = '0; wr_addr_seen = '0;
    for (int i = 0; i < 16; i++) begin
      filled[i] = '0;
      evicted[i] = '0;
    end
    acc_edge = edge_cnt + 1;
  endtask

  // Compare all outputs with the step at the head of the script, then advance it.
  task automatic model_step();
    int k, w;
    logic [23:0] e_addr;
    if (!reset_n) begin
      q.delete();
      m_idx = '0; m_tag = '0; m_vtag = '0;
    end
    k = (q.size() == 0) ? K_IDLE : q[0].kind;
    w = (q.size() == 0) ? 0 : q[0].word;
    e_addr = (k == K_RDREQ) ? {m_idx, m_tag, 5'b0} : (k == K_WRREQ) ? {m_idx, m_vtag, 5'b0} : 24'h0;
    chk("busy", busy, k != K_IDLE);
    chk("done", done, k == K_DONE);
    chk("readreq", readreq, k == K_RDREQ);
    chk("writereq", writereq, k == K_WRREQ);
    chk("ram_addr", ram_addr, e_addr);
    chk("write", write, (k == K_EVICT) && writeready);
    chk("read", read, (k == K_FILL) && readready);
    chk("line_wr_en", line_wr_en, (k == K_FILL) && readready);
    chk("tag_wr", tag_wr, (k == K_INVAL) || (k == K_TAG));
    chk("valid_out", valid_out, k == K_TAG);
    chk("word_sel", word_sel, ((k == K_EVICT) || (k == K_FILL)) ? w : 0);
    chk("line_index", line_index, m_idx);
    chk("tag_out", tag_out, m_tag);
    if (k == K_EVICT) chk("data_to_ram", data_to_ram, 16'hA000 + w);
    if ((k == K_FILL) && readready) chk("line_wr_data", line_wr_data, 16'hC000 + pop_cnt);

    if (readreq === 1'b1) begin readreq_cnt++; rd_addr_seen = ram_addr; end
    if (writereq === 1'b1) begin writereq_cnt++; wr_addr_seen = ram_addr; end
    if (line_wr_en === 1'b1) begin read_cnt++; filled[word_sel] = line_wr_data; end
    if (write === 1'b1) begin
      if (write_cnt < 16) evicted[write_cnt] = data_to_ram;
      write_cnt++;
    end
    if (tag_wr === 1'b1) begin
      if (valid_out === 1'b1) tag1_cnt++;
      else tag0_cnt++;
    end
    if ((done === 1'b1) && !done_seen) begin
      done_seen = 1'b1;
      done_edge = edge_cnt + 1;
    end

    pop_pending = 1'b0;
    if (reset_n) begin
      if (k == K_IDLE) begin
        if (miss === 1'b1) accept_miss();
      end else if (k == K_EVICT) begin
        if (writeready) void'(q.pop_front());
      end else if (k == K_FILL) begin
        if (readready) begin
          void'(q.pop_front());
          pop_pending = 1'b1;
        end
      end else begin
        void'(q.pop_front());
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    model_step();
    @(posedge clock);
    edge_cnt++;
    #1;
    if (pop_pending) begin
      pop_cnt++;
      data_from_ram = 16'hC000 + pop_cnt[15:0];
    end
  endtask

  task automatic run_miss(input string tname, input logic [23:0] a, input logic vv, input logic vd,
                          input logic [TW-1:0] vt, input bit bp_rd, input bit bp_wr, input bit extra,
                          input int exp_lat, input int exp_wreq, input logic [23:0] exp_wr_addr);
    int n;
    miss = 1'b1; miss_addr = a; victim_valid = vv; victim_dirty = vd; victim_tag = vt;
    pop_cnt = 0; data_from_ram = 16'hC000;
    tick();
    miss = 1'b0; miss_addr = ~a; victim_valid = ~vv; victim_dirty = ~vd; victim_tag = ~vt;
    n = 0;
    while (!done_seen && (n < 400)) begin
      if (bp_rd) readready = ~readready;
      if (bp_wr) writeready = ~writeready;
      miss = (extra && (n == 5));
      tick();
      n++;
    end
    miss = 1'b0; readready = 1'b1; writeready = 1'b1;
    tick();
    chk({tname, " done_seen"}, done_seen, 1'b1);
    chk({tname, " readreq_cnt"}, readreq_cnt, 1);
    chk({tname, " rd_addr"}, rd_addr_seen, {a[23:5], 5'b0});
    chk({tname, " writereq_cnt"}, writereq_cnt, exp_wreq);
    chk({tname, " read_cnt"}, read_cnt, 16);
    chk({tname, " write_cnt"}, write_cnt, 16 * exp_wreq);
    chk({tname, " tag_invalidate_cnt"}, tag0_cnt, 1);
    chk({tname, " tag_valid_cnt"}, tag1_cnt, 1);
    if (exp_lat != 0) chk({tname, " latency"}, done_edge - acc_edge, exp_lat);
    if (exp_wreq != 0) begin
      chk({tname, " wr_addr"}, wr_addr_seen, exp_wr_addr);
      for (int i = 0; i < 16; i++) chk({tname, " evict_word"}, evicted[i], 16'hA000 + i);
    end
    for (int i = 0; i < 16; i++) chk({tname, " fill_word"}, filled[i], 16'hC000 + i);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; miss = 1'b0; miss_addr = '0; victim_valid = 1'b0; victim_dirty = 1'b0;
    victim_tag = '0; readready = 1'b1; writeready = 1'b1; data_from_ram = '0; pop_cnt = 0;
    readreq_cnt = 0; writereq_cnt = 0; read_cnt = 0; write_cnt = 0; tag0_cnt = 0; tag1_cnt = 0;
    done_seen = 1'b0;
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset ram_addr", ram_addr, 24'h0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    run_miss("clean", 24'hABCDE0, 1'b0, 1'b0, 8'h00, 0, 0, 0, 20, 0, 24'h0);
    run_miss("dirty", 24'h2AA780, 1'b1, 1'b1, 8'h02, 0, 0, 0, 37, 1, 24'h2AA040);
`ifdef DIRTY_TRACK_EN
    run_miss("clean_valid", 24'h123440, 1'b1, 1'b0, 8'h5B, 0, 0, 0, 20, 0, 24'h0);
`else
    run_miss("clean_valid", 24'h123440, 1'b1, 1'b0, 8'h5B, 0, 0, 0, 37, 1, 24'h122B60);
`endif
    run_miss("bp_read", 24'h000FE0, 1'b0, 1'b0, 8'h00, 1, 0, 0, 0, 0, 24'h0);
    run_miss("bp_both", 24'hFFE020, 1'b1, 1'b1, 8'hC3, 1, 1, 0, 0, 1, 24'hFFF860);
    run_miss("miss_busy", 24'h2AA780, 1'b1, 1'b1, 8'h02, 0, 0, 1, 37, 1, 24'h2AA040);

    // Abort a clean refill while word 7 is being filled.
    miss = 1'b1; miss_addr = 24'h3579A0; victim_valid = 1'b0; victim_dirty = 1'b0; victim_tag = '0;
    pop_cnt = 0; data_from_ram = 16'hC000;
    tick();
    miss = 1'b0;
    n = 0;
    while (!((q.size() > 0) && (q[0].kind == K_FILL) && (q[0].word == 7)) && (n < 40)) begin
      tick();
      n++;
    end
    chk("reach fill word 7", n < 40, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort readreq", readreq, 1'b0);
    chk("abort read", read, 1'b0);
    chk("abort tag_wr", tag_wr, 1'b0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("abort words filled", read_cnt, 7);
    chk("abort tag_invalidate_cnt", tag0_cnt, 1);
    chk("abort tag_valid_cnt", tag1_cnt, 0);
    chk("abort done", done_seen, 1'b0);

    run_miss("after_reset", 24'hABCDE0, 1'b0, 1'b0, 8'h00, 0, 0, 0, 20, 0, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
